// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and the canonical NOP word.
package cpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StExec,
        StHalt,
        StFault
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding fetch at a time, halt/single-step
// support, bus-error and timeout faults that stick until reset.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_err,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        pc_en,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] instret
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

    fetch_state_t    r_state;
    fetch_state_t    w_state_d;
    logic [31:0]     r_addr;
    logic [31:0]     w_addr_d;
    logic [31:0]     r_instr;
    logic [31:0]     w_instr_d;
    logic [31:0]     r_fault_pc;
    logic [31:0]     w_fault_pc_d;
    logic [31:0]     r_instret;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic [CntW-1:0] w_cnt_inc;
    logic            r_step;
    logic            w_step_d;
    logic            w_retire;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_instr    <= NOP_INSTR;
            r_fault_pc <= '0;
            r_instret  <= '0;
            r_cnt      <= '0;
            r_step     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_addr     <= w_addr_d;
            r_instr    <= w_instr_d;
            r_fault_pc <= w_fault_pc_d;
            r_cnt      <= w_cnt_d;
            r_step     <= w_step_d;
            // Only written on retirement so the count is otherwise left untouched.
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_addr_d     = r_addr;
        w_instr_d    = r_instr;
        w_fault_pc_d = r_fault_pc;
        w_cnt_d      = r_cnt;
        w_step_d     = r_step;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        imem_addr    = r_addr;
        instr_valid  = 1'b0;
        pc_en        = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StReq;
                end
            end
            StReq: begin
                // Address comes straight from the PC here; it is frozen for WAIT.
                imem_req  = 1'b1;
                imem_addr = word_align(pc_in);
                w_addr_d  = word_align(pc_in);
                w_cnt_d   = '0;
                w_state_d = StWait;
            end
            StWait: begin
                imem_req = 1'b1;
                w_cnt_d  = w_cnt_inc;
                if (imem_err) begin
                    w_fault_pc_d = r_addr;
                    w_state_d    = StFault;
                end else if (imem_ack) begin
                    w_instr_d = imem_rdata;
                    w_state_d = StExec;
                end else if (w_cnt_inc == TimeoutVal) begin
                    w_fault_pc_d = r_addr;
                    w_state_d    = StFault;
                end
            end
            StExec: begin
                instr_valid = 1'b1;
                pc_en       = 1'b1;
                w_retire    = 1'b1;
                w_step_d    = 1'b0;
                if (halt_req || r_step) begin
                    w_state_d = StHalt;
                end else begin
                    w_state_d = StReq;
                end
            end
            StHalt: begin
                halted = 1'b1;
                if (step_req) begin
                    w_step_d  = 1'b1;
                    w_state_d = StReq;
                end else if (!halt_req) begin
                    w_state_d = StReq;
                end
            end
            StFault: begin
                fault = 1'b1;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign instr_out = r_instr;
    assign fault_pc  = r_fault_pc;
    assign instret   = r_instret;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: normal fetch, halt/step, faults, timeout, wrap, reset.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        step_req;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_err;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        pc_en;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] instret;

    int n_checks = 0;
    int n_errors = 0;
    int n_wait;

    fetch_ctrl #(
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .pc_in      (pc_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_err   (imem_err),
        .imem_rdata (imem_rdata),
        .instr_out  (instr_out),
        .instr_valid(instr_valid),
        .pc_en      (pc_en),
        .halted     (halted),
        .fault      (fault),
        .fault_pc   (fault_pc),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},     {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},    imem_addr,            32'd0);
        chk({tag, "_instr"},   instr_out,            32'h0000_0013);
        chk({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
        chk({tag, "_pcen"},    {31'd0, pc_en},       32'd0);
        chk({tag, "_halted"},  {31'd0, halted},      32'd0);
        chk({tag, "_fault"},   {31'd0, fault},       32'd0);
        chk({tag, "_faultpc"}, fault_pc,             32'd0);
        chk({tag, "_instret"}, instret,              32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        halt_req   = 1'b0;
        step_req   = 1'b0;
        pc_in      = 32'h0;
        imem_ack   = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = 32'h0;
        tick();
        tick();
        chk_reset_vals("rst");

        // Basic fetch: ack two cycles after the request
        rst_n = 1'b1;
        pc_in = 32'h100;
        start = 1'b1;
        tick();
        chk("req_strobe", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, 32'h100);
        start = 1'b0;
        tick();
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        pc_in = 32'h104;
        #1;
        chk("wait_addr_stable", imem_addr, 32'h100);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_pcen", {31'd0, pc_en}, 32'd1);
        chk("exec_instr", instr_out, 32'hDEAD_BEEF);
        chk("exec_req_low", {31'd0, imem_req}, 32'd0);
        tick();
        chk("post_exec_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_exec_instret", instret, 32'd1);
        chk("next_req_addr", imem_addr, 32'h104);

        // halt_req during WAIT: finish the instruction, then halt
        tick();
        halt_req = 1'b1;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        imem_ack = 1'b0;
        chk("halt_exec_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        chk("halted_1", {31'd0, halted}, 32'd1);
        chk("halted_instret", instret, 32'd2);
        chk("halted_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("halted_hold", {31'd0, halted}, 32'd1);

        // One step pulse -> exactly one instruction
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_req", {31'd0, imem_req}, 32'd1);
        chk("step_not_halted", {31'd0, halted}, 32'd0);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_2222;
        tick();
        imem_ack = 1'b0;
        chk("step_valid", {31'd0, instr_valid}, 32'd1);
        chk("step_instr", instr_out, 32'h2222_2222);
        tick();
        chk("step_rehalt", {31'd0, halted}, 32'd1);
        chk("step_instret", instret, 32'd3);
        tick();
        chk("step_no_more", {31'd0, instr_valid}, 32'd0);

        // Resume, then ack and err together at 0x40: err wins
        halt_req = 1'b0;
        pc_in    = 32'h40;
        tick();
        chk("resume_addr", imem_addr, 32'h40);
        tick();
        imem_ack = 1'b1;
        imem_err = 1'b1;
        tick();
        imem_ack = 1'b0;
        imem_err = 1'b0;
        chk("err_fault", {31'd0, fault}, 32'd1);
        chk("err_fault_pc", fault_pc, 32'h40);
        chk("err_valid", {31'd0, instr_valid}, 32'd0);
        chk("err_instret", instret, 32'd3);
        chk("err_req", {31'd0, imem_req}, 32'd0);
        start = 1'b1;
        tick();
        tick();
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        chk("fault_pcen", {31'd0, pc_en}, 32'd0);
        chk("fault_req", {31'd0, imem_req}, 32'd0);

        // Timeout: no response, TIMEOUT=4
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("to_rst_fault", {31'd0, fault}, 32'd0);
        pc_in = 32'h203;
        tick();
        chk("to_req_addr", imem_addr, 32'h200);
        tick();
        n_wait = 0;
        while (!fault && n_wait < 20) begin
            if (imem_req) n_wait++;
            tick();
        end
        chk("to_wait_cycles", n_wait, 32'd4);
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_fault_pc", fault_pc, 32'h200);
        chk("to_req_low", {31'd0, imem_req}, 32'd0);

        // instret wrap
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        pc_in = 32'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_3333;
        tick();
        imem_ack = 1'b0;
        chk("wrap_pre", instret, 32'hFFFF_FFFF);
        tick();
        chk("wrap_post", instret, 32'd0);

        // Reset mid-WAIT, then a stray ack in IDLE
        tick();
        chk("rw_in_wait", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("rw");
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h4444_4444;
        tick();
        chk("stray_valid_1", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("stray_valid_2", {31'd0, instr_valid}, 32'd0);
        chk("stray_instr", instr_out, 32'h0000_0013);
        chk("stray_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum number of cycles spent in WAIT before a fault.
REQ-002 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 start  input  1  SHALL be the level that enables fetching out of IDLE.
REQ-005 halt_req  input  1  SHALL be the level requesting a halt after the current instruction.
REQ-006 step_req  input  1  SHALL be a pulse that executes exactly one instruction while halted.
REQ-007 pc_in  input  32  SHALL carry the current PC from the program counter.
REQ-008 imem_req  output  1  SHALL be the instruction memory request strobe.
REQ-009 imem_addr  output  32  SHALL be the fetch address, word aligned.
REQ-010 imem_ack  input  1  SHALL be the memory response-valid signal.
REQ-011 imem_err  input  1  SHALL be the memory bus error signal.
REQ-012 imem_rdata  input  32  SHALL carry the instruction word, valid only with imem_ack.
REQ-013 instr_out  output  32  SHALL carry the latched instruction for decode.
REQ-014 instr_valid  output  1  SHALL be high for one cycle per instruction to execute.
REQ-015 pc_en  output  1  SHALL permit the program counter to update at the next rising edge.
REQ-016 halted  output  1  SHALL be high while in HALT.
REQ-017 fault  output  1  SHALL be high while in FAULT.
REQ-018 fault_pc  output  32  SHALL hold the address of the fetch that faulted.
REQ-019 instret  output  32  SHALL count retired instructions.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT, EXEC, HALT and FAULT.
REQ-021 IDLE: start=1 SHALL move the FSM to REQ; otherwise it SHALL stay in IDLE.
REQ-022 REQ: imem_req=1 and imem_addr={pc_in[31:2],2'b00} for exactly one cycle, then WAIT.
REQ-023 WAIT: imem_req SHALL remain high and imem_addr SHALL remain stable until imem_ack or imem_err.
REQ-024 WAIT: imem_ack=1 SHALL latch imem_rdata into instr_out and move the FSM to EXEC.
REQ-025 WAIT: imem_err=1 SHALL move the FSM to FAULT and latch imem_addr into fault_pc; err SHALL take priority over ack in the same cycle.
REQ-026 WAIT: the timeout counter SHALL clear on entry; if the counter reaches TIMEOUT without ack or err, the FSM SHALL go to FAULT with fault_pc set.
REQ-027 EXEC: instr_valid=1 and pc_en=1 for exactly one cycle, and instret SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-028 EXEC exit: halt_req=1 or an active single-step SHALL move the FSM to HALT; otherwise it SHALL move to REQ, giving a minimum of 3 cycles per instruction.
REQ-029 halt_req asserted during REQ or WAIT SHALL NOT abort the fetch; the instruction SHALL complete EXEC and then halt.
REQ-030 HALT: step_req=1 SHALL set the single-step flag and move the FSM to REQ; halt_req=0 without step_req SHALL move the FSM to REQ.
REQ-031 FAULT SHALL be sticky until reset, with imem_req, pc_en and instr_valid held at 0.
REQ-032 pc_en and instr_valid SHALL be 0 in every state other than EXEC.

Reset
REQ-033 When rst_n=0 at a clock edge: state=IDLE, imem_req=0, imem_addr=0, instr_out=0x00000013 (NOP), instr_valid=0, pc_en=0, halted=0, fault=0, fault_pc=0, instret=0, timeout counter=0, step flag=0.
REQ-034 Reset mid-WAIT SHALL drop imem_req at that edge; a late imem_ack in IDLE SHALL be ignored.

Structure
REQ-035 The fetch_state_t enum and the NOP constant SHALL live in the shared package cpu_pkg.
REQ-036 The block SHALL be a single module with no sub-module; the timeout counter is inline, with width $clog2(TIMEOUT+1).

Verification
REQ-037 Scenario: start=1, ack 2 cycles after req, pc_in=0x100, rdata=0xDEADBEEF -> imem_addr=0x100; then instr_valid=1, pc_en=1, instr_out=0xDEADBEEF for one cycle; instret=1.
REQ-038 Scenario: imem_ack and imem_err both asserted in WAIT at pc 0x40 -> fault=1, fault_pc=0x40, instr_valid stays 0, instret unchanged.
REQ-039 Scenario: no ack with TIMEOUT=4 -> FAULT entered after 4 WAIT cycles; imem_req=0 thereafter.
REQ-040 Scenario: halt_req=1 during WAIT -> instruction completes EXEC, then halted=1; one step_req pulse -> exactly one instr_valid pulse, then halted=1 again.
REQ-041 Scenario: instret preset to 0xFFFFFFFF by running the required cycles or by force -> next EXEC gives instret=0.
REQ-042 Scenario: rst_n=0 during WAIT -> all outputs at REQ-033 values at the next edge; a subsequent stray ack causes no instr_valid.
